softmax_job_scheduler: RTL and testbench
========================================

// Module: softmax_job_scheduler
// PURPOSE
//  Sequences one shared softmax engine among NUM_REQ requesters. Each job is an address
//  range in on-chip memory. Arbitrates round-robin, then drives the engine's init/start.
//  Waits for done (with timeout), snapshots the NUM_OUT results, then streams them back
//  tagged with the requester ID. Sits between the layer controllers and the softmax datapath.
// PARAMETERS
//  NUM_REQ    2     number of requesters (>=2)
//  ADDRSIZE   7     memory address width
//  DATAWIDTH  16    fp16 result width
//  NUM_OUT    8     results produced per job
//  TIMEOUT    1023  max cycles from start to done before abort
// PORTS
//  clk           in   1                   clock
//  reset         in   1                   asynchronous, active-low reset
//  req_valid     in   NUM_REQ             job request per requester
//  req_ready     out  NUM_REQ             one-hot accept, high one cycle
//  req_start     in   NUM_REQ*ADDRSIZE    packed start addresses
//  req_end       in   NUM_REQ*ADDRSIZE    packed end addresses
//  sm_init       out  1                   latch-address pulse to engine
//  sm_start      out  1                   start pulse to engine
//  sm_start_addr out  ADDRSIZE            held for the whole job
//  sm_end_addr   out  ADDRSIZE            held for the whole job
//  sm_done       in   1                   engine done (level, rising edge used)
//  sm_outp       in   NUM_OUT*DATAWIDTH   engine results, valid when done rises
//  res_valid     out  1                   result stream valid
//  res_ready     in   1                   result stream ready
//  res_data      out  DATAWIDTH           result word
//  res_idx       out  clog2(NUM_OUT)      word index 0..NUM_OUT-1
//  res_last      out  1                   high with idx NUM_OUT-1
//  res_id        out  clog2(NUM_REQ)      owning requester
//  err_valid     out  1                   one-cycle error pulse
//  err_code      out  2                   01 bad range, 10 timeout
//  busy          out  1                   state != IDLE
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, rr pointer 0, buffer cleared. Reset mid-job aborts
//    immediately, with no error and no result.
//  - FSM: IDLE -> INIT -> START -> WAIT -> DRAIN -> IDLE.
//  - IDLE: grant = first valid requester at or after the rr pointer. req_ready[grant]=1 in the
//    same cycle (combinational on req_valid). Capture addr and id. Pointer <= grant+1 (wrap).
//  - Bad range (end < start): accept and pulse err_valid/err_code=01 next cycle, then stay
//    IDLE. No engine pulses.
//  - INIT: sm_init=1 for one cycle. START: sm_start=1 for one cycle. Accept at T gives init at
//    T+1 and start at T+2.
//  - WAIT: a counter increments per cycle. On the sm_done rising edge, copy sm_outp to the
//    buffer and go to DRAIN. If the count reaches TIMEOUT with no done: err_code=10 pulse and
//    go to IDLE. Done and timeout in the same cycle: done wins.
//  - DRAIN: res_valid=1, idx from 0. Advance only on valid&&ready; data held stable while
//    stalled. res_last with idx NUM_OUT-1. Handshake on last -> IDLE. The next grant is
//    possible in the cycle after.
//  - sm_done already high on entry to WAIT is ignored until it drops and rises again.
//  - No new request accepted outside IDLE. req_ready is 0 outside IDLE.
//  - Engine addresses are held from accept until re-accept; they are not cleared at IDLE.
// STRUCTURE
//  - softmax_ctrl_pkg: state_t enum, err-code localparams, clog2 width helpers.
//  - Sub-module rr_arbiter (NUM_REQ; req, ptr -> one-hot grant, index). Everything else is
//    inline: FSM, timeout counter, NUM_OUT x DATAWIDTH result buffer, drain counter.
// TESTING
//  1. Single job: req0 start=0 end=7 -> ready0 at T, init T+1, start T+2. Done at T+10 ->
//     8 words idx 0..7 match sm_outp, last on idx 7, id=0.
//  2. Fairness: both valid continuously -> grants alternate 0,1,0,1 over 4 jobs.
//  3. Backpressure: res_ready toggling 1010 -> no word lost or duplicated; data stable while
//     stalled.
//  4. Bad range: start=9 end=3 -> err 01 pulse; no sm_init/sm_start; next job proceeds normally.
//  5. Timeout: done never asserted -> err 10 exactly TIMEOUT cycles after WAIT entry; then
//     IDLE with busy=0.
//  6. Reset asserted during DRAIN idx 3 -> outputs 0 at once; after release, req1 is granted
//     first (pointer back to 0, req0 idle).

Source files
------------

// File: rtl/softmax_ctrl_pkg.sv
// Shared definitions for the softmax job scheduler.
//   state_t      : scheduler FSM states
//   ERR_*        : codes reported on err_code
//   clog_w()     : index width helper that never returns 0
package softmax_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_START,
    S_WAIT,
    S_DRAIN
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_RANGE   = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  // Width needed to index n items; at least one bit so ports never collapse.
  function automatic int clog_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter.
//   req   : request vector
//   ptr   : highest-priority requester index this cycle
//   grant : one-hot grant (all zero when nothing requests)
//   idx   : binary index of the granted requester
//   any   : at least one request present
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDW     = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     idx,
  output logic               any
);

  // Scan starting at ptr and wrapping; the first hit wins.
  always_comb begin
    int j;
    logic found;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = (int'(ptr) + i) % NUM_REQ;
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = IDW'(j);
      end
    end
    any = found;
  end

endmodule

// File: rtl/softmax_job_scheduler.sv
// Shares one softmax engine among NUM_REQ requesters.
//   req_valid/req_ready/req_start/req_end : job requests (address ranges), one-hot accept
//   sm_init/sm_start/sm_*_addr            : engine control, addresses held per job
//   sm_done/sm_outp                       : engine completion and NUM_OUT results
//   res_*                                 : tagged result stream, valid/ready handshake
//   err_valid/err_code                    : one-cycle error pulse (01 bad range, 10 timeout)
//   busy                                  : scheduler not idle
module softmax_job_scheduler
  import softmax_ctrl_pkg::*;
#(
  parameter  int NUM_REQ   = 2,
  parameter  int ADDRSIZE  = 7,
  parameter  int DATAWIDTH = 16,
  parameter  int NUM_OUT   = 8,
  parameter  int TIMEOUT   = 1023,
  localparam int IDW       = clog_w(NUM_REQ),
  localparam int IDXW      = clog_w(NUM_OUT)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ADDRSIZE-1:0]   req_start,
  input  logic [NUM_REQ*ADDRSIZE-1:0]   req_end,
  output logic                          sm_init,
  output logic                          sm_start,
  output logic [ADDRSIZE-1:0]           sm_start_addr,
  output logic [ADDRSIZE-1:0]           sm_end_addr,
  input  logic                          sm_done,
  input  logic [NUM_OUT*DATAWIDTH-1:0]  sm_outp,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [DATAWIDTH-1:0]          res_data,
  output logic [IDXW-1:0]               res_idx,
  output logic                          res_last,
  output logic [IDW-1:0]                res_id,
  output logic                          err_valid,
  output logic [1:0]                    err_code,
  output logic                          busy
);

  localparam int              CW      = clog_w(TIMEOUT + 1);
  localparam logic [CW-1:0]   TO_LAST = CW'(TIMEOUT - 1);
  localparam logic [IDXW-1:0] IDX_END = IDXW'(NUM_OUT - 1);
  localparam logic [IDW-1:0]  ID_END  = IDW'(NUM_REQ - 1);

  state_t                 state, state_nxt;
  logic [IDW-1:0]         ptr;
  logic [NUM_REQ-1:0]     grant;
  logic [IDW-1:0]         gidx;
  logic                   any;
  logic [IDW-1:0]         id_q;
  logic                   done_q;
  logic [CW-1:0]          wcnt;
  logic [IDXW-1:0]        didx;
  logic [DATAWIDTH-1:0]   buffer [NUM_OUT];

  logic [ADDRSIZE-1:0]    sel_start, sel_end;
  logic                   accept, bad_range, done_rise, timeout_hit, drain_fire, last_fire;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_arb (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (gidx),
    .any   (any)
  );

  assign sel_start   = req_start[int'(gidx)*ADDRSIZE +: ADDRSIZE];
  assign sel_end     = req_end[int'(gidx)*ADDRSIZE +: ADDRSIZE];
  assign accept      = (state == S_IDLE) && any;
  assign bad_range   = sel_end < sel_start;
  // Edge detect so a done level left over from an earlier job cannot complete this one.
  assign done_rise   = sm_done && !done_q;
  assign timeout_hit = (state == S_WAIT) && !done_rise && (wcnt == TO_LAST);
  assign drain_fire  = (state == S_DRAIN) && res_ready;
  assign last_fire   = drain_fire && (didx == IDX_END);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept && !bad_range) state_nxt = S_INIT;
      S_INIT:  state_nxt = S_START;
      S_START: state_nxt = S_WAIT;
      S_WAIT: begin
        if (done_rise)        state_nxt = S_DRAIN;
        else if (timeout_hit) state_nxt = S_IDLE;
      end
      S_DRAIN: if (last_fire) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode; req_ready is forced low while reset is held so nothing looks accepted.
  always_comb begin
    req_ready = '0;
    sm_init   = 1'b0;
    sm_start  = 1'b0;
    res_valid = 1'b0;
    res_last  = 1'b0;
    busy      = (state != S_IDLE);
    case (state)
      S_IDLE:  if (reset) req_ready = grant;
      S_INIT:  sm_init = 1'b1;
      S_START: sm_start = 1'b1;
      S_DRAIN: begin
        res_valid = 1'b1;
        res_last  = (didx == IDX_END);
      end
      default: ;
    endcase
  end

  assign res_data = buffer[didx];
  assign res_idx  = didx;
  assign res_id   = id_q;

  // Job capture, wait counter, result buffer, drain index and error pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr           <= '0;
      id_q          <= '0;
      sm_start_addr <= '0;
      sm_end_addr   <= '0;
      done_q        <= 1'b0;
      wcnt          <= '0;
      didx          <= '0;
      err_valid     <= 1'b0;
      err_code      <= ERR_NONE;
      for (int i = 0; i < NUM_OUT; i++) buffer[i] <= '0;
    end else begin
      done_q    <= sm_done;
      err_valid <= 1'b0;
      err_code  <= ERR_NONE;

      if (accept) begin
        sm_start_addr <= sel_start;
        sm_end_addr   <= sel_end;
        id_q          <= gidx;
        ptr           <= (gidx == ID_END) ? '0 : gidx + 1'b1;
        if (bad_range) begin
          err_valid <= 1'b1;
          err_code  <= ERR_RANGE;
        end
      end

      if (state == S_WAIT) wcnt <= wcnt + 1'b1;
      else                 wcnt <= '0;

      if (timeout_hit) begin
        err_valid <= 1'b1;
        err_code  <= ERR_TIMEOUT;
      end

      if ((state == S_WAIT) && done_rise) begin
        for (int i = 0; i < NUM_OUT; i++) buffer[i] <= sm_outp[i*DATAWIDTH +: DATAWIDTH];
      end

      if (state != S_DRAIN)  didx <= '0;
      else if (last_fire)    didx <= '0;
      else if (drain_fire)   didx <= didx + 1'b1;
    end
  end

endmodule

// File: tb/tb_softmax_job_scheduler.sv
module tb_softmax_job_scheduler;

  localparam int NR = 2;
  localparam int AW = 7;
  localparam int DW = 16;
  localparam int NO = 8;
  localparam int TO = 1023;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*AW-1:0]  req_start;
  logic [NR*AW-1:0]  req_end;
  logic              sm_init, sm_start;
  logic [AW-1:0]     sm_start_addr, sm_end_addr;
  logic              sm_done;
  logic [NO*DW-1:0]  sm_outp;
  logic              res_valid;
  logic              res_ready;
  logic [DW-1:0]     res_data;
  logic [2:0]        res_idx;
  logic              res_last;
  logic [0:0]        res_id;
  logic              err_valid;
  logic [1:0]        err_code;
  logic              busy;

  softmax_job_scheduler #(
    .NUM_REQ(NR), .ADDRSIZE(AW), .DATAWIDTH(DW), .NUM_OUT(NO), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_start(req_start), .req_end(req_end),
    .sm_init(sm_init), .sm_start(sm_start),
    .sm_start_addr(sm_start_addr), .sm_end_addr(sm_end_addr),
    .sm_done(sm_done), .sm_outp(sm_outp),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_idx(res_idx), .res_last(res_last), .res_id(res_id),
    .err_valid(err_valid), .err_code(err_code), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [2:0]    idx;
    logic          last;
    logic [0:0]    id;
  } exp_t;

  exp_t       sb[$];
  logic [1:0] err_q[$];
  int         total  = 0;
  int         passed = 0;
  logic       bp_mode = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [NO*DW-1:0] mk_outp(input logic [DW-1:0] base);
    logic [NO*DW-1:0] r;
    r = '0;
    for (int i = 0; i < NO; i++) r[i*DW +: DW] = base + DW'(i * 16'h0111);
    return r;
  endfunction

  task automatic push_job(input int id, input logic [DW-1:0] base);
    exp_t e;
    for (int i = 0; i < NO; i++) begin
      e.data = base + DW'(i * 16'h0111);
      e.idx  = 3'(i);
      e.last = (i == NO - 1);
      e.id   = 1'(id);
      sb.push_back(e);
    end
  endtask

  task automatic set_req(input int id, input logic [AW-1:0] s, input logic [AW-1:0] e);
    req_start[id*AW +: AW] = s;
    req_end[id*AW +: AW]   = e;
  endtask

  // Called at a negedge; checks the grant once one appears (bounded).
  task automatic wait_grant(input logic [NR-1:0] exp);
    int n;
    n = 0;
    while (req_ready == '0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("grant", 32'(req_ready), 32'(exp));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("return_idle", 32'(busy), 0);
  endtask

  // Called just after the accept edge; raises done in cycle accept+d.
  task automatic fire_done(input logic [DW-1:0] base, input int d);
    repeat (d - 1) @(posedge clk);
    #1;
    sm_outp = mk_outp(base);
    sm_done = 1'b1;
  endtask

  // res_ready driver: constant high, or toggling every cycle in backpressure mode.
  initial begin
    res_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode) res_ready = ~res_ready;
      else         res_ready = 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every result handshake and every error pulse.
  initial begin
    logic          stalled;
    logic [DW-1:0] h_data;
    logic [2:0]    h_idx;
    exp_t          e;
    stalled = 1'b0;
    h_data  = '0;
    h_idx   = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        stalled = 1'b0;
      end else begin
        if (stalled && res_valid) begin
          chk("stall_data", 32'(res_data), 32'(h_data));
          chk("stall_idx", 32'(res_idx), 32'(h_idx));
        end
        if (res_valid && res_ready) begin
          if (sb.size() == 0) begin
            total++;
            $display("FAIL unexpected_result: got idx %0d data %0h, none expected", res_idx, res_data);
          end else begin
            e = sb.pop_front();
            chk("res_data", 32'(res_data), 32'(e.data));
            chk("res_idx", 32'(res_idx), 32'(e.idx));
            chk("res_last", 32'(res_last), 32'(e.last));
            chk("res_id", 32'(res_id), 32'(e.id));
          end
        end
        stalled = res_valid && !res_ready;
        h_data  = res_data;
        h_idx   = res_idx;
        if (err_valid) begin
          if (err_q.size() == 0) begin
            total++;
            $display("FAIL unexpected_err: got code %0b, none expected", err_code);
          end else begin
            chk("err_code", 32'(err_code), 32'(err_q.pop_front()));
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $display("%0d/%0d checks passed", passed, total + 1);
    $fatal(1);
  end

  initial begin
    int n;
    req_valid = '0;
    req_start = '0;
    req_end   = '0;
    sm_done   = 1'b0;
    sm_outp   = '0;

    // Reset state, with a request pending to show nothing is accepted
    repeat (3) @(negedge clk);
    req_valid = 2'b01;
    #1;
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_sm_init", 32'(sm_init), 0);
    chk("rst_err_valid", 32'(err_valid), 0);
    chk("rst_start_addr", 32'(sm_start_addr), 0);
    @(posedge clk); #1;
    req_valid = '0;
    reset = 1'b1;

    // 1: single job, req0 0..7, done at T+10
    @(posedge clk); #1;
    set_req(0, 7'd0, 7'd7);
    req_valid = 2'b01;
    @(negedge clk);
    wait_grant(2'b01);
    chk("t1_init_at_T", 32'(sm_init), 0);
    @(posedge clk); #1;
    req_valid = '0;
    push_job(0, 16'h1000);
    @(negedge clk);
    chk("t1_init", 32'(sm_init), 1);
    chk("t1_start_early", 32'(sm_start), 0);
    chk("t1_ready_busy", 32'(req_ready), 0);
    chk("t1_saddr", 32'(sm_start_addr), 0);
    chk("t1_eaddr", 32'(sm_end_addr), 7);
    @(negedge clk);
    chk("t1_start", 32'(sm_start), 1);
    chk("t1_init_off", 32'(sm_init), 0);
    repeat (8) @(posedge clk);
    #1;
    sm_outp = mk_outp(16'h1000);
    sm_done = 1'b1;
    @(negedge clk);
    chk("t1_valid_at_done", 32'(res_valid), 0);
    @(negedge clk);
    chk("t1_valid_after", 32'(res_valid), 1);
    chk("t1_first_idx", 32'(res_idx), 0);
    wait_idle();
    chk("t1_all_words", sb.size(), 0);
    chk("t1_addr_held", 32'(sm_end_addr), 7);

    // 4: bad range on req1, then normal traffic continues
    @(posedge clk); #1;
    sm_done = 1'b0;
    set_req(1, 7'd9, 7'd3);
    req_valid = 2'b10;
    @(negedge clk);
    wait_grant(2'b10);
    err_q.push_back(2'b01);
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    chk("t4_err_pulse", 32'(err_valid), 1);
    chk("t4_no_init", 32'(sm_init), 0);
    chk("t4_busy", 32'(busy), 0);
    @(negedge clk);
    chk("t4_no_start", 32'(sm_start), 0);
    chk("t4_err_once", 32'(err_valid), 0);

    // 2: fairness with both requesters always valid
    @(posedge clk); #1;
    set_req(0, 7'd1, 7'd6);
    set_req(1, 7'd8, 7'd100);
    req_valid = 2'b11;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      wait_grant((k % 2 == 0) ? 2'b01 : 2'b10);
      @(posedge clk); #1;
      sm_done = 1'b0;
      if (k == 3) req_valid = '0;
      push_job(k % 2, 16'h2000 + 16'(k * 16'h0800));
      fire_done(16'h2000 + 16'(k * 16'h0800), 5);
      wait_idle();
      chk("t2_words", sb.size(), 0);
    end

    // 3: backpressure with res_ready toggling
    @(posedge clk); #1;
    sm_done = 1'b0;
    set_req(0, 7'd3, 7'd50);
    req_valid = 2'b01;
    @(negedge clk);
    wait_grant(2'b01);
    @(posedge clk); #1;
    req_valid = '0;
    bp_mode = 1'b1;
    push_job(0, 16'h4A00);
    fire_done(16'h4A00, 6);
    wait_idle();
    bp_mode = 1'b0;
    chk("t3_words", sb.size(), 0);

    // 5: timeout, done never asserted
    @(posedge clk); #1;
    sm_done = 1'b0;
    set_req(0, 7'd2, 7'd5);
    req_valid = 2'b01;
    @(negedge clk);
    wait_grant(2'b01);
    err_q.push_back(2'b10);
    @(posedge clk); #1;
    req_valid = '0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!err_valid && n < 1100);
    chk("t5_timeout_cycle", n, 3 + TO);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_no_result", 32'(res_valid), 0);

    // 5b: done already high when WAIT starts; only the next rising edge counts
    @(posedge clk); #1;
    sm_outp = mk_outp(16'hDE00);
    sm_done = 1'b1;
    set_req(1, 7'd10, 7'd20);
    req_valid = 2'b10;
    @(negedge clk);
    wait_grant(2'b10);
    @(posedge clk); #1;
    req_valid = '0;
    push_job(1, 16'h5500);
    repeat (7) @(posedge clk);
    #1;
    sm_done = 1'b0;
    @(negedge clk);
    chk("t5b_still_wait", 32'(busy), 1);
    chk("t5b_no_drain", 32'(res_valid), 0);
    fire_done(16'h5500, 4);
    wait_idle();
    chk("t5b_words", sb.size(), 0);

    // 6: reset during DRAIN at idx 3
    @(posedge clk); #1;
    sm_done = 1'b0;
    set_req(0, 7'd4, 7'd4);
    req_valid = 2'b01;
    @(negedge clk);
    wait_grant(2'b01);
    @(posedge clk); #1;
    req_valid = '0;
    push_job(0, 16'h6600);
    fire_done(16'h6600, 5);
    n = 0;
    while (!(res_valid && res_idx == 3'd3) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t6_reached_idx3", 32'(res_idx), 3);
    reset = 1'b0;
    sm_done = 1'b0;
    set_req(1, 7'd0, 7'd15);
    req_valid = 2'b10;
    #1;
    chk("t6_res_valid", 32'(res_valid), 0);
    chk("t6_res_idx", 32'(res_idx), 0);
    chk("t6_res_data", 32'(res_data), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_req_ready", 32'(req_ready), 0);
    chk("t6_saddr", 32'(sm_start_addr), 0);
    chk("t6_err", 32'(err_valid), 0);
    chk("t6_pending_left", sb.size(), 5);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    wait_grant(2'b10);
    @(posedge clk); #1;
    req_valid = '0;
    push_job(1, 16'h7700);
    fire_done(16'h7700, 5);
    wait_idle();
    chk("t6_words", sb.size(), 0);

    repeat (3) @(negedge clk);
    chk("err_all_seen", err_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
